// File: rtl/multiboot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multiboot_ctrl
// Brief    : Spartan-6 multiboot controller; picks a bitstream by slot or
//            direct SPI address, waits a hold-off, then streams IPROG to ICAP.
//            Optional abort input enabled by MULTIBOOT_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multiboot_ctrl #(
  parameter int          NUM_SLOTS    = 4,
  parameter int          SLOT_W       = 2,
  parameter logic [23:0] SLOT_BASE    = 24'h000000,
  parameter logic [23:0] SLOT_SIZE    = 24'h080000,
  parameter logic [23:0] FALLBACK_ADR = 24'h000000,
  parameter logic [7:0]  READ_OPCODE  = 8'h03,
  parameter int          ARM_DELAY    = 1000,
  parameter int          STROBE_DIV   = 1,
  parameter bit          BIT_SWAP     = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              boot_i,
  input  logic              use_adr_i,
  input  logic [SLOT_W-1:0] boot_slot_i,
  input  logic [23:0]       boot_adr_i,
`ifdef MULTIBOOT_ABORT_EN
  input  logic              abort_i,
`endif
  output logic              busy_o,
  output logic              err_o,
  output logic              done_o,
  output logic              icap_ce_o,
  output logic              icap_we_o,
  output logic [15:0]       icap_o
);

  localparam int c_CNT_W = (ARM_DELAY < 1) ? 1 : $clog2(ARM_DELAY + 1);
  localparam int c_DIV_W = (STROBE_DIV < 2) ? 1 : $clog2(STROBE_DIV);
  localparam int c_SLT_W = SLOT_W + 1;
  localparam logic [c_CNT_W-1:0] c_ARM_LAST  = c_CNT_W'(ARM_DELAY);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(STROBE_DIV - 1);
  localparam logic [c_SLT_W-1:0] c_NUM_SLOTS = c_SLT_W'(NUM_SLOTS);
  localparam logic [3:0]         c_LAST_WORD = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  logic [23:0]          r_adr;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_DIV_W-1:0]   r_div;
  logic [3:0]           r_idx;

  logic                 w_slot_ok;
  logic                 w_accept;
  logic                 w_abort;
  logic [23:0]          w_slot_adr;
  logic [23:0]          w_target_adr;

  // ICAP sees configuration bytes MSB-first on bit 0, hence the per-byte flip.
  function automatic logic [15:0] f_swap(input logic [15:0] w);
    logic [15:0] r;
    r = w;
    if (BIT_SWAP) begin
      for (int i = 0; i < 8; i++) begin
        r[i]     = w[7-i];
        r[8+i]   = w[15-i];
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] f_word(input logic [3:0] idx, input logic [23:0] adr);
    logic [15:0] w;
    case (idx)
      4'd0:    w = 16'hFFFF;
      4'd1:    w = 16'hAA99;
      4'd2:    w = 16'h5566;
      4'd3:    w = 16'h3261;
      4'd4:    w = adr[15:0];
      4'd5:    w = 16'h3281;
      4'd6:    w = {READ_OPCODE, adr[23:16]};
      4'd7:    w = 16'h32A1;
      4'd8:    w = FALLBACK_ADR[15:0];
      4'd9:    w = 16'h32C1;
      4'd10:   w = {READ_OPCODE, FALLBACK_ADR[23:16]};
      4'd11:   w = 16'h30A1;
      4'd12:   w = 16'h000E;
      4'd13:   w = 16'h2000;
      default: w = 16'hFFFF;
    endcase
    return w;
  endfunction

  assign w_slot_ok    = {1'b0, boot_slot_i} < c_NUM_SLOTS;
  assign w_slot_adr   = SLOT_BASE + 24'(boot_slot_i) * SLOT_SIZE;
  assign w_target_adr = use_adr_i ? boot_adr_i : w_slot_adr;
  assign w_accept     = boot_i & (use_adr_i | w_slot_ok);

`ifdef MULTIBOOT_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_adr     <= 24'h000000;
      r_cnt     <= '0;
      r_div     <= '0;
      r_idx     <= 4'd0;
      busy_o    <= 1'b0;
      err_o     <= 1'b0;
      done_o    <= 1'b0;
      icap_ce_o <= 1'b1;
      icap_we_o <= 1'b1;
      icap_o    <= 16'hFFFF;
    end else begin
      err_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_adr   <= w_target_adr;
            r_cnt   <= '0;
            busy_o  <= 1'b1;
            r_state <= S_DELAY;
          end else if (boot_i) begin
            err_o <= 1'b1;
          end
        end
        S_DELAY: begin
          if (w_abort) begin
            r_adr   <= 24'h000000;
            busy_o  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == c_ARM_LAST) begin
            r_idx     <= 4'd0;
            r_div     <= '0;
            icap_o    <= f_swap(f_word(4'd0, r_adr));
            icap_ce_o <= 1'b0;
            icap_we_o <= 1'b0;
            r_state   <= S_SEND;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SEND: begin
          if (r_div == c_DIV_LAST) begin
            r_div <= '0;
            if (r_idx == c_LAST_WORD) begin
              icap_ce_o <= 1'b1;
              icap_we_o <= 1'b1;
              icap_o    <= 16'hFFFF;
              done_o    <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_idx  <= r_idx + 4'd1;
              icap_o <= f_swap(f_word(r_idx + 4'd1, r_adr));
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
